// File: rtl/display_scroll_if.sv
// display_scroll_if -- signal bundle between a character source / controller
// and display_scroll_ctrl.
//   master : drives wr_valid, wr_data, start, mode, loop, clear;
//            observes wr_ready, display_ctrl, display_buf0..3, busy, done.
//   slave  : the scroll controller itself (directions reversed).
interface display_scroll_if;
   logic       wr_valid;
   logic [7:0] wr_data;
   logic       wr_ready;
   logic       start;
   logic       mode;
   logic       loop;
   logic       clear;
   logic       display_ctrl;
   logic [7:0] display_buf0;
   logic [7:0] display_buf1;
   logic [7:0] display_buf2;
   logic [7:0] display_buf3;
   logic       busy;
   logic       done;

   modport master (
      output wr_valid, wr_data, start, mode, loop, clear,
      input  wr_ready, display_ctrl, display_buf0, display_buf1,
             display_buf2, display_buf3, busy, done
   );

   modport slave (
      input  wr_valid, wr_data, start, mode, loop, clear,
      output wr_ready, display_ctrl, display_buf0, display_buf1,
             display_buf2, display_buf3, busy, done
   );
endinterface

// File: rtl/display_scroll_ctrl.sv
// display_scroll_ctrl -- stores a short message and scrolls it right-to-left
// across a 4-digit display, one character per step, followed by four blanks.
// Ports:
//   clk    : system clock, all state changes on its rising edge
//   reset  : synchronous, active-high
//   bus    : display_scroll_if.slave
//            wr_valid/wr_data/wr_ready : message write handshake (IDLE only)
//            start/mode/loop/clear     : pass control
//            display_ctrl, display_buf0..3 : display drive (buf0 leftmost)
//            busy, done                : pass in progress / end-of-pass pulse
module display_scroll_ctrl #(
   parameter int DEPTH       = 16,
   parameter int STEP_CYCLES = 12_500_000
) (
   input  logic            clk,
   input  logic            reset,
   display_scroll_if.slave bus
);

   localparam int IDX_W  = $clog2(DEPTH);
   localparam int CNT_W  = IDX_W + 1;
   localparam int STEP_W = $clog2(STEP_CYCLES);
   localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);

   typedef enum logic [1:0] {IDLE, SCROLL, FLUSH} state_t;

   state_t            state;
   logic [CNT_W-1:0]  count;
   logic [IDX_W-1:0]  index;
   logic [STEP_W-1:0] step_cnt;
   logic [1:0]        flush_cnt;
   logic              disp_ctrl;
   logic [7:0]        disp_buf [4];
   logic              busy_q;
   logic              done_q;
   logic [7:0]        msg_mem [DEPTH];

   logic       wr_acc;
   logic       start_acc;
   logic       tick;
   logic       last_char;
   logic [7:0] blank;
   logic [7:0] next_char;

   // Writes are only taken in IDLE with room left; reset masks it immediately.
   assign bus.wr_ready = !reset && (state == IDLE) && (count < CNT_FULL);
   assign wr_acc       = bus.wr_valid && bus.wr_ready;
   // A start colliding with an accepted write is dropped.
   assign start_acc    = bus.start && (state == IDLE) && (count != '0) && !wr_acc;
   assign tick         = (state != IDLE) && (step_cnt == STEP_LAST);
   assign last_char    = ({1'b0, index} == count - CNT_W'(1));
   assign blank        = disp_ctrl ? 8'h00 : 8'h10;
   assign next_char    = (state == SCROLL) ? msg_mem[index] : blank;

   // NOTE: the message store has no reset; only entries below count are ever
   // read, and the stored message must survive clear/IDLE for replay.
   always_ff @(posedge clk) begin
      if (!reset && !bus.clear && wr_acc)
         msg_mem[count[IDX_W-1:0]] <= bus.wr_data;
   end

   // NOTE: non-blocking assignments throughout, so every right-hand side sees
   // the pre-edge value (the buffer shift depends on it).
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         count     <= '0;
         index     <= '0;
         step_cnt  <= '0;
         flush_cnt <= '0;
         disp_ctrl <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         for (int i = 0; i < 4; i++) disp_buf[i] <= 8'h10;
      end else if (bus.clear) begin
         // Clear keeps display_ctrl, so the blank matches the current mode.
         state     <= IDLE;
         count     <= '0;
         index     <= '0;
         step_cnt  <= '0;
         flush_cnt <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         for (int i = 0; i < 4; i++) disp_buf[i] <= blank;
      end else begin
         done_q <= 1'b0;
         if (wr_acc) count <= count + CNT_W'(1);

         if (tick) begin
            disp_buf[0] <= disp_buf[1];
            disp_buf[1] <= disp_buf[2];
            disp_buf[2] <= disp_buf[3];
            disp_buf[3] <= next_char;
         end

         unique case (state)
            IDLE: begin
               step_cnt <= '0;
               if (start_acc) begin
                  disp_ctrl <= bus.mode;
                  index     <= '0;
                  busy_q    <= 1'b1;
                  state     <= SCROLL;
               end
            end
            SCROLL: begin
               step_cnt <= tick ? '0 : step_cnt + STEP_W'(1);
               if (tick) begin
                  if (last_char) begin
                     state     <= FLUSH;
                     flush_cnt <= '0;
                  end else begin
                     index <= index + IDX_W'(1);
                  end
               end
            end
            FLUSH: begin
               step_cnt <= tick ? '0 : step_cnt + STEP_W'(1);
               if (tick) begin
                  flush_cnt <= flush_cnt + 2'd1;
                  if (flush_cnt == 2'd3) begin
                     done_q <= 1'b1;
                     index  <= '0;
                     if (bus.loop) begin
                        state <= SCROLL;
                     end else begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.display_ctrl = disp_ctrl;
   assign bus.display_buf0 = disp_buf[0];
   assign bus.display_buf1 = disp_buf[1];
   assign bus.display_buf2 = disp_buf[2];
   assign bus.display_buf3 = disp_buf[3];
   assign bus.busy         = busy_q;
   assign bus.done         = done_q;

endmodule

// File: doc/display_scroll_ctrl.md
DISPLAY_SCROLL_CTRL -- requirements
Module: display_scroll_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 16: message buffer entries, power of two, 4 to 64.
REQ-002 SHALL have parameter STEP_CYCLES, default 12_500_000: clk cycles per scroll step, at least 2.
REQ-003 SHALL have port clk  input  1: the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-005 SHALL have port wr_valid  input  1: a character code is offered.
REQ-006 SHALL have port wr_data  input  8: the offered character code.
REQ-007 SHALL have port wr_ready  output  1: the block can accept a character.
REQ-008 SHALL have port start  input  1: one-cycle pulse that begins a scroll pass.
REQ-009 SHALL have port mode  input  1: display mode (0 pattern, 1 raw), sampled on an accepted start.
REQ-010 SHALL have port loop  input  1: level; repeat the pass while high.
REQ-011 SHALL have port clear  input  1: one-cycle pulse that aborts and empties the block.
REQ-012 SHALL have ports display_ctrl  output  1, and display_buf0..display_buf3  output  8 each: drive the 4-digit display (buf0 leftmost, buf3 rightmost).
REQ-013 SHALL have port busy  output  1: a pass is in progress.
REQ-014 SHALL have port done  output  1: one-cycle pulse at the end of each pass.

Function
REQ-015 SHALL use a blank code BLANK = 8'h10 when display_ctrl=0 and 8'h00 when display_ctrl=1.
REQ-016 SHALL implement states IDLE, SCROLL and FLUSH.
REQ-017 SHALL, in IDLE only, drive wr_ready = (count < DEPTH); in every other state wr_ready=0.
REQ-018 SHALL, on wr_valid&&wr_ready, store wr_data at index count and increment count; wr_valid while wr_ready=0 is ignored and loses the byte.
REQ-019 SHALL, on start in IDLE with count>0 and no write accepted that cycle, do all of the following on the next edge: latch mode into display_ctrl, reset the step counter and read index to 0, and enter SCROLL with busy=1.
REQ-020 SHALL ignore start when count=0, when a write is accepted in the same cycle, or when not in IDLE.
REQ-021 SHALL generate a step tick every STEP_CYCLES cycles while busy, with the first tick STEP_CYCLES cycles after entering SCROLL.
REQ-022 SHALL, on each tick, shift buf1->buf0, buf2->buf1 and buf3->buf2, and load a new char into buf3.
REQ-023 SHALL, in SCROLL, load message[index] as the new char and increment index; after the tick that loads index count-1, enter FLUSH.
REQ-024 SHALL, in FLUSH, load BLANK as the new char for exactly 4 ticks; on the 4th tick pulse done=1 for one cycle.
REQ-025 SHALL, on the 4th FLUSH tick, re-enter SCROLL with index=0 and the step counter restarted if loop=1; otherwise enter IDLE with busy=0. The message is retained in both cases.
REQ-026 SHALL keep buffer contents unchanged between ticks.
REQ-027 SHALL give clear priority over start and write: on the next edge the state goes to IDLE, count=0, all buffers=BLANK for the current display_ctrl, busy=0, and no done pulse; this applies in any state.
REQ-028 SHALL keep the message contents unchanged after the block returns to IDLE, so that a new start replays the stored message.
REQ-029 SHALL keep the step counter at 0 while in IDLE.

Reset
REQ-030 SHALL, while reset=1, drive: state IDLE, count=0, index=0, step counter 0, display_ctrl=0, display_buf0..3=8'h10, busy=0, done=0, wr_ready=0.
REQ-031 SHALL assert wr_ready=1 on the first cycle after reset is deasserted.
REQ-032 SHALL, when reset is asserted mid-pass, abort immediately to the reset values with no done pulse.

Verification (STEP_CYCLES=4, DEPTH=4)
REQ-033 SHALL cover basic pass: write 01,02,03; start, mode=0 -> ticks at +4,+8,+12 leave buf0..3 = 10,10,10,01 / 10,10,01,02 / 10,01,02,03; after 4 flush ticks all 10; done pulses once; busy falls.
REQ-034 SHALL cover full buffer: write 4 codes -> wr_ready=0; a 5th wr_valid is dropped and count stays 4.
REQ-035 SHALL cover empty start and collision: start with count=0 -> busy stays 0; start in the same cycle as an accepted write -> start ignored and count=1.
REQ-036 SHALL cover loop: loop=1 with a message of 1 code 0A -> done pulses every 5 ticks and buf3=0A on ticks 1, 6, 11; after loop drops, the block goes to IDLE after the next done.
REQ-037 SHALL cover raw-mode clear: mode=1, clear issued mid-SCROLL -> next cycle busy=0, all bufs=00, count=0, display_ctrl=1, no done pulse.
REQ-038 SHALL cover reset mid-FLUSH: reset asserted -> all outputs take their REQ-030 reset values the next cycle.
